seq_match_ctrl: RTL and testbench
=================================

SEQ_MATCH_CTRL -- requirements
Module: seq_match_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning match-counter and threshold width.
REQ-002 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  high = accept new bytes.
REQ-005 SHALL have port cfg_pattern  input  4  target bit pattern, first-received bit in bit 3.
REQ-006 SHALL have port cfg_threshold  input  CNT_W  match count that raises irq; 0 = irq disabled.
REQ-007 SHALL have port in_valid  input  1  byte offered.
REQ-008 SHALL have port in_data  input  8  byte, serialized MSB first.
REQ-009 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-010 SHALL have port irq_clr  input  1  clears irq and match_count.
REQ-011 SHALL have port busy  output  1  high while bits are being shifted.
REQ-012 SHALL have port match_pulse  output  1  one-cycle pulse per detected match.
REQ-013 SHALL have port match_count  output  CNT_W  saturating match count.
REQ-014 SHALL have port irq  output  1  sticky threshold interrupt.

Function
REQ-015 FSM SHALL have states IDLE and SHIFT; IDLE->SHIFT on accepted byte; SHIFT->IDLE after 8th bit unless a new byte is accepted in that cycle.
REQ-016 in_ready SHALL be enable && (state==IDLE || (state==SHIFT && bit index==7)), giving back-to-back throughput of 8 cycles/byte with no bubble.
REQ-017 In SHIFT, one bit per cycle SHALL shift into a 4-bit history register, MSB of the byte first; busy = (state==SHIFT).
REQ-018 History and a 3-bit fill count (saturating at 4) SHALL persist across byte boundaries and IDLE periods; matches span bytes.
REQ-019 match_pulse SHALL assert in the cycle after the shift that makes history==cfg_pattern with fill count>=4; overlapping matches SHALL each count.
REQ-020 match_count SHALL increment on each match_pulse and saturate at 2^CNT_W-1.
REQ-021 irq SHALL set in the cycle after match_count changes to a value equal to cfg_threshold (threshold!=0), and hold until irq_clr.
REQ-022 irq_clr SHALL clear irq and match_count next cycle, with priority over a same-cycle increment; match_pulse is still issued.
REQ-023 Deasserting enable mid-byte SHALL let the current byte finish; no new byte accepted until enable returns.
REQ-024 cfg_pattern changes SHALL take effect on the next compare; history is not cleared.

Reset
REQ-025 reset SHALL force state=IDLE, history=0, fill count=0, bit index=0, match_pulse=0, match_count=0, irq=0, busy=0; in_ready=enable after reset.
REQ-026 reset mid-byte SHALL discard remaining bits of that byte; no match_pulse issued for the discarded bits.

Structure
REQ-027 Shared package SHALL hold the FSM state encoding (IDLE=0, SHIFT=1), PAT_W=4, and BYTE_W=8.
REQ-028 Compare logic SHALL be the sub-module seq_pattern_det (bit in, shift enable, pattern in, match out), instantiated once.

Verification
REQ-029 pattern=1011, one byte 0xB0 -> exactly one match_pulse, 5 cycles after acceptance (after 4th bit), match_count=1.
REQ-030 pattern=1011, byte 0x5B -> two overlapping match_pulses, after bits 5 and 8; match_count=2.
REQ-031 pattern=1011, bytes 0x01 then 0x60 back-to-back -> in_ready high in last shift cycle, one match during second byte's 3rd bit, match_count=1.
REQ-032 threshold=2, bytes 0xB0,0xB0 -> irq rises after second match and stays; irq_clr with a coincident match -> irq=0, match_count=0.
REQ-033 CNT_W=8, 300 matching bytes 0xB0 -> match_count holds 255; threshold=0 -> irq never asserts.
REQ-034 reset asserted at bit 2 of 0xB0 -> all outputs at reset values, no match_pulse; next 0xB0 -> one match after 4 bits.

Source files
------------

// File: rtl/seq_match_ctrl_pkg.sv
// Shared definitions for the serial pattern-match controller:
// FSM state encoding and the pattern/byte widths.
package seq_match_ctrl_pkg;

   localparam int PAT_W  = 4;
   localparam int BYTE_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/seq_pattern_det.sv
// Bit-serial pattern detector. It keeps a PAT_W-bit history that spans byte
// boundaries and idle gaps, and raises match one cycle after the shift that completes it.
module seq_pattern_det
   import seq_match_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_in,
   input  logic             shift_en,
   input  logic [PAT_W-1:0] pattern,
   output logic             match
);

   logic [PAT_W-1:0] history;
   logic [2:0]       fill;
   logic             cmp_pending;

   // The compare uses the registered history. A pattern change made between
   // the shift and the compare therefore still counts.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         history     <= '0;
         fill        <= '0;
         cmp_pending <= 1'b0;
         match       <= 1'b0;
      end else begin
         match       <= cmp_pending && (fill >= 3'(PAT_W)) && (history == pattern);
         cmp_pending <= shift_en;
         if (shift_en) begin
            history <= {history[PAT_W-2:0], bit_in};
            if (fill != 3'(PAT_W))
               fill <= fill + 3'd1;
         end
      end
   end

endmodule

// File: rtl/seq_match_ctrl.sv
// Byte-in, bit-serial sequence matcher. It counts occurrences of a 4-bit pattern
// and raises a sticky interrupt when the match count reaches a threshold.
module seq_match_ctrl
   import seq_match_ctrl_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [3:0]       cfg_pattern,
   input  logic [CNT_W-1:0] cfg_threshold,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   input  logic             irq_clr,
   output logic             busy,
   output logic             match_pulse,
   output logic [CNT_W-1:0] match_count,
   output logic             irq
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state, state_nxt;
   logic [BYTE_W-1:0] shreg;
   logic [2:0]        bit_idx;
   logic              last_bit;
   logic              accept;
   logic              inc_d;

   assign last_bit = (state == SHIFT) && (bit_idx == 3'd7);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (last_bit && !accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Ready is also asserted in the last shift cycle, so a new byte loads with no bubble.
   always_comb begin
      in_ready = enable && ((state == IDLE) || last_bit);
      busy     = (state == SHIFT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg   <= '0;
         bit_idx <= '0;
      end else if (accept) begin
         shreg   <= in_data;
         bit_idx <= '0;
      end else if (state == SHIFT) begin
         shreg   <= {shreg[BYTE_W-2:0], 1'b0};
         bit_idx <= bit_idx + 3'd1;
      end
   end

   seq_pattern_det u_det (
      .clk      (clk),
      .reset    (reset),
      .bit_in   (shreg[BYTE_W-1]),
      .shift_en (busy),
      .pattern  (cfg_pattern),
      .match    (match_pulse)
   );

   // inc_d marks a cycle in which the count has just changed. The irq compare is
   // made against that new value, so a saturated count never re-fires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         match_count <= '0;
         inc_d       <= 1'b0;
         irq         <= 1'b0;
      end else if (irq_clr) begin
         match_count <= '0;
         inc_d       <= 1'b0;
         irq         <= 1'b0;
      end else begin
         inc_d <= 1'b0;
         if (match_pulse && (match_count != CNT_MAX)) begin
            match_count <= match_count + 1'b1;
            inc_d       <= 1'b1;
         end
         if (inc_d && (cfg_threshold != '0) && (match_count == cfg_threshold))
            irq <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Scoreboard bench for seq_match_ctrl. A bit-level model predicts the cycle of
// each match_pulse when a byte is accepted, and a monitor pops and compares them.
module tb_seq_match_ctrl;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b1;
   logic [3:0]       cfg_pattern = 4'b1011;
   logic [CNT_W-1:0] cfg_threshold = '0;
   logic             in_valid = 1'b0;
   logic [7:0]       in_data = '0;
   logic             in_ready;
   logic             irq_clr = 1'b0;
   logic             busy;
   logic             match_pulse;
   logic [CNT_W-1:0] match_count;
   logic             irq;

   seq_match_ctrl #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .cfg_pattern   (cfg_pattern),
      .cfg_threshold (cfg_threshold),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .irq_clr       (irq_clr),
      .busy          (busy),
      .match_pulse   (match_pulse),
      .match_count   (match_count),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   total = 0;
   int   passed = 0;
   int   sb[$];
   int   exp_cyc;
   logic [3:0] m_hist = '0;
   int   m_fill = 0;
   bit   irq_seen = 1'b0;

   always @(negedge clk) begin
      if (irq === 1'b1) irq_seen = 1'b1;
      if (match_pulse === 1'b1) begin
         total++;
         if (sb.size() == 0)
            $display("FAIL match_timing: unexpected match_pulse at cycle %0d, none expected", cyc);
         else begin
            exp_cyc = sb.pop_front();
            if (cyc !== exp_cyc)
               $display("FAIL match_timing: pulse at cycle %0d, expected cycle %0d", cyc, exp_cyc);
            else
               passed++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
      $fatal(1, "watchdog");
   end

   task automatic model_byte(input logic [7:0] b, input int acc);
      for (int i = 0; i < 8; i++) begin
         m_hist = {m_hist[2:0], b[7-i]};
         if (m_fill < 4) m_fill++;
         if (m_fill >= 4 && m_hist == cfg_pattern) sb.push_back(acc + i + 2);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit model, output int acc);
      int waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (in_ready !== 1'b1) begin
         total++;
         $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
         acc = -1;
      end else begin
         acc = cyc + 1;
         if (model) model_byte(b, acc);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; irq_clr = 1'b0; enable = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_hist = '0; m_fill = 0; sb.delete();
   endtask

   task automatic check_drained(input string name);
      total++;
      if (sb.size() != 0) $display("FAIL %s_drain: %0d pulses missing, expected 0", name, sb.size());
      else passed++;
   endtask

   task automatic test_reset();
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (match_pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", match_pulse); else passed++;
      total++; if (match_count !== '0) $display("FAIL reset_count: got %0d want 0", match_count); else passed++;
      total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else passed++;
      enable = 1'b0; #1;
      total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_dis: got %b want 0", in_ready); else passed++;
      enable = 1'b1;
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_single();
      int acc;
      do_reset(); cfg_pattern = 4'b1011; cfg_threshold = '0;
      send_byte(8'hB0, 1'b1, acc);
      wait_cycles(12);
      total++; if (match_count !== 8'd1) $display("FAIL single_count: got %0d want 1", match_count); else passed++;
      check_drained("single");
   endtask

   task automatic test_overlap();
      int acc;
      do_reset();
      send_byte(8'h5B, 1'b1, acc);
      wait_cycles(12);
      total++; if (match_count !== 8'd2) $display("FAIL overlap_count: got %0d want 2", match_count); else passed++;
      check_drained("overlap");
   endtask

   task automatic test_back_to_back();
      int acc1, acc2;
      do_reset();
      send_byte(8'h01, 1'b1, acc1);
      send_byte(8'h60, 1'b1, acc2);
      total++; if (acc2 - acc1 !== 8) $display("FAIL b2b_spacing: got %0d cycles want 8", acc2 - acc1); else passed++;
      wait_cycles(12);
      total++; if (match_count !== 8'd1) $display("FAIL b2b_count: got %0d want 1", match_count); else passed++;
      check_drained("b2b");
   endtask

   task automatic test_irq();
      int acc, waited;
      do_reset(); cfg_threshold = 8'd2;
      send_byte(8'hB0, 1'b1, acc);
      wait_cycles(12);
      total++; if (irq !== 1'b0) $display("FAIL irq_early: got %b want 0", irq); else passed++;
      send_byte(8'hB0, 1'b1, acc);
      wait_cycles(12);
      total++; if (match_count !== 8'd2) $display("FAIL irq_count: got %0d want 2", match_count); else passed++;
      total++; if (irq !== 1'b1) $display("FAIL irq_set: got %b want 1", irq); else passed++;
      wait_cycles(5);
      total++; if (irq !== 1'b1) $display("FAIL irq_sticky: got %b want 1", irq); else passed++;
      send_byte(8'hB0, 1'b1, acc);
      waited = 0;
      while (match_pulse !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (match_pulse !== 1'b1) $display("FAIL irq_clr_pulse: got %b want 1 within 20 cycles", match_pulse);
      else passed++;
      irq_clr = 1'b1;
      @(posedge clk);
      #1 irq_clr = 1'b0;
      total++; if (match_count !== '0) $display("FAIL irq_clr_count: got %0d want 0", match_count); else passed++;
      total++; if (irq !== 1'b0) $display("FAIL irq_clr_irq: got %b want 0", irq); else passed++;
      wait_cycles(2);
      total++; if (match_count !== '0) $display("FAIL irq_clr_hold: got %0d want 0", match_count); else passed++;
      check_drained("irq");
      cfg_threshold = '0;
   endtask

   task automatic test_saturate();
      int acc;
      do_reset(); cfg_threshold = '0; irq_seen = 1'b0;
      for (int n = 0; n < 300; n++) send_byte(8'hB0, 1'b1, acc);
      wait_cycles(12);
      total++; if (match_count !== 8'd255) $display("FAIL sat_count: got %0d want 255", match_count); else passed++;
      total++; if (irq_seen !== 1'b0) $display("FAIL sat_irq: irq seen=%b want 0", irq_seen); else passed++;
      check_drained("sat");
   endtask

   task automatic test_reset_mid();
      int acc;
      do_reset();
      send_byte(8'hB0, 1'b0, acc);
      repeat (3) @(negedge clk);
      reset = 1'b1; #1;
      total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b want 1", in_ready); else passed++;
      total++; if (match_count !== '0) $display("FAIL rmid_count: got %0d want 0", match_count); else passed++;
      @(negedge clk);
      reset = 1'b0; m_hist = '0; m_fill = 0; sb.delete();
      wait_cycles(12);
      total++; if (match_count !== '0) $display("FAIL rmid_nopulse: got %0d want 0", match_count); else passed++;
      send_byte(8'hB0, 1'b1, acc);
      wait_cycles(12);
      total++; if (match_count !== 8'd1) $display("FAIL rmid_after: got %0d want 1", match_count); else passed++;
      check_drained("rmid");
   endtask

   task automatic test_enable();
      int acc;
      do_reset();
      send_byte(8'h00, 1'b1, acc);
      enable = 1'b0; in_valid = 1'b1; in_data = 8'hB0;
      wait_cycles(3);
      total++; if (busy !== 1'b1) $display("FAIL en_midbyte_busy: got %b want 1", busy); else passed++;
      wait_cycles(10);
      total++; if (busy !== 1'b0) $display("FAIL en_idle_busy: got %b want 0", busy); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL en_in_ready: got %b want 0", in_ready); else passed++;
      in_valid = 1'b0; enable = 1'b1; #1;
      total++; if (in_ready !== 1'b1) $display("FAIL en_restore: got %b want 1", in_ready); else passed++;
      total++; if (match_count !== '0) $display("FAIL en_count: got %0d want 0", match_count); else passed++;
      check_drained("en");
   endtask

   initial begin
      test_reset();
      test_single();
      test_overlap();
      test_back_to_back();
      test_irq();
      test_saturate();
      test_reset_mid();
      test_enable();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
